// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem req/ack, 2-entry prefetch
// queue, and registered instruction/PC/bubble outputs to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_out_o,
  output logic [31:0] pc_out_o,
  output logic        bubble_out_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  entry_t          q0_q, q0_d, q1_q, q1_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] cnt_pop;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            bubble_q, bubble_d;
  logic            pop, push;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      q0_q       <= '0;
      q1_q       <= '0;
      count_q    <= '0;
      instr_q    <= NOP;
      pc_q       <= RESET_PC;
      bubble_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      bubble_q   <= bubble_d;
    end
  end

  // Next-state: queue pop/push, fetch FSM, redirect override
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    q0_d       = q0_q;
    q1_d       = q1_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    bubble_d   = bubble_q;

    // Pop only from entries present before this edge, so no push-to-pop bypass
    pop     = !redirect_i && !stall_i && (count_q != 2'd0);
    push    = !redirect_i && (state_q == WAIT) && imem_ack_i &&
              ((count_q != 2'd2) || pop);
    cnt_pop = count_q - CNTW'(pop);
    count_d = cnt_pop + CNTW'(push);

    if (pop) begin
      q0_d = q1_q;
    end
    if (push) begin
      if (cnt_pop == 2'd0) begin
        q0_d = '{instr: imem_rdata_i, pc: fetch_pc_q};
      end else begin
        q1_d = '{instr: imem_rdata_i, pc: fetch_pc_q};
      end
    end

    if (!redirect_i && !stall_i) begin
      if (count_q != 2'd0) begin
        instr_d  = q0_q.instr;
        pc_d     = q0_q.pc;
        bubble_d = 1'b0;
      end else begin
        instr_d  = NOP;
        bubble_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!redirect_i && (count_q != 2'd2)) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (push) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_d == 2'd2) begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (imem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An unacked request stays on the bus in DISCARD until its response is dropped
    if (redirect_i) begin
      count_d    = '0;
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      state_d    = ((state_q != IDLE) && !imem_ack_i) ? DISCARD : IDLE;
      instr_d    = NOP;
      pc_d       = fetch_pc_d;
      bubble_d   = 1'b1;
    end

    req_d  = (state_d != IDLE);
    addr_d = (state_d == DISCARD) ? addr_q : fetch_pc_d;
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign instr_out_o  = instr_q;
  assign pc_out_o     = pc_q;
  assign bubble_out_o = bubble_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural queue model compared every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_out_o;
  logic [31:0] pc_out_o;
  logic        bubble_out_o;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_out_o   (instr_out_o),
    .pc_out_o      (pc_out_o),
    .bubble_out_o  (bubble_out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder settings
  int          mem_lat;
  int          mem_cnt;
  bit          force_valid;
  logic [31:0] force_data;

  // Behavioural model
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  localparam int M_IDLE = 0, M_WAIT = 1, M_DISC = 2;
  ent_t        mq[$];
  int          m_mode;
  logic [31:0] m_fpc, m_addr, m_instr, m_pc;
  logic        m_req, m_bub;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_mode  = M_IDLE;
    m_fpc   = 32'h0;
    m_addr  = 32'h0;
    m_req   = 1'b0;
    m_instr = 32'h0;
    m_pc    = 32'h0;
    m_bub   = 1'b1;
  endfunction

  function automatic void model_step(input logic a, input logic [31:0] d, input logic st,
                                     input logic rd, input logic [31:0] rpc);
    int   n0;
    ent_t e;
    if (rd) begin
      if ((m_mode == M_WAIT || m_mode == M_DISC) && !a) m_mode = M_DISC;
      else m_mode = M_IDLE;
      mq.delete();
      m_fpc   = {rpc[31:2], 2'b00};
      m_instr = 32'h0;
      m_pc    = m_fpc;
      m_bub   = 1'b1;
    end else begin
      n0 = mq.size();
      if (!st) begin
        if (n0 > 0) begin
          e = mq.pop_front();
          m_instr = e.instr;
          m_pc    = e.pc;
          m_bub   = 1'b0;
        end else begin
          m_instr = 32'h0;
          m_bub   = 1'b1;
        end
      end
      if (m_mode == M_IDLE) begin
        if (n0 < 2) m_mode = M_WAIT;
      end else if (m_mode == M_WAIT) begin
        if (a) begin
          e.instr = d;
          e.pc    = m_fpc;
          mq.push_back(e);
          m_fpc = m_fpc + 32'd4;
          if (mq.size() >= 2) m_mode = M_IDLE;
        end
      end else begin
        if (a) m_mode = M_IDLE;
      end
    end
    m_req = (m_mode != M_IDLE);
    if (m_mode != M_DISC) m_addr = m_fpc;
  endfunction

  task automatic compare();
    chk("instr_out", instr_out_o, m_instr);
    chk("pc_out", pc_out_o, m_pc);
    chk("bubble_out", 32'(bubble_out_o), 32'(m_bub));
    chk("imem_req", 32'(imem_req_o), 32'(m_req));
    chk("imem_addr", imem_addr_o, m_addr);
  endtask

  // One clock cycle: drive inputs and memory response, advance model, compare
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
    logic        a;
    logic [31:0] d;
    a = imem_req_o && (mem_cnt >= mem_lat);
    d = a ? (force_valid ? force_data : imem_addr_o) : 32'hBAD0_0BAD;
    imem_ack_i    = a;
    imem_rdata_i  = d;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    if (a) begin
      mem_cnt     = 0;
      force_valid = 0;
    end else if (imem_req_o) begin
      mem_cnt++;
    end
    @(posedge clk);
    model_step(a, d, st, rd, rpc);
    #1;
    compare();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_instr"}, instr_out_o, 32'h0);
    chk({tag, "_pc"}, pc_out_o, 32'h0);
    chk({tag, "_bubble"}, 32'(bubble_out_o), 32'd1);
    chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = 32'h0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    mem_cnt       = 0;
    force_valid   = 0;
    model_reset();
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = 32'h0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    mem_lat       = 0;
    mem_cnt       = 0;
    force_valid   = 0;
    force_data    = 32'h0;
    #2;

    // Zero-wait memory returning the address
    do_reset("rst0");
    cycle(0, 0, 0);
    chk("zw_first_req", 32'(imem_req_o), 32'd1);
    chk("zw_first_addr", imem_addr_o, 32'h0);
    repeat (3) cycle(0, 0, 0);
    chk("zw_e4_instr", instr_out_o, 32'h4);
    chk("zw_e4_pc", pc_out_o, 32'h4);
    chk("zw_e4_bubble", 32'(bubble_out_o), 32'd0);
    chk("zw_e4_addr", imem_addr_o, 32'hC);
    repeat (2) cycle(0, 0, 0);
    chk("zw_e6_instr", instr_out_o, 32'hC);

    // Stall 4 cycles: queue fills, request drops, outputs frozen
    repeat (4) cycle(1, 0, 0);
    chk("stall_frozen_instr", instr_out_o, 32'hC);
    chk("stall_req_low", 32'(imem_req_o), 32'd0);
    cycle(0, 0, 0);
    chk("stall_rel_1", instr_out_o, 32'h10);
    cycle(0, 0, 0);
    chk("stall_rel_2", instr_out_o, 32'h14);
    repeat (6) cycle(0, 0, 0);

    // 3-cycle ack latency
    mem_lat = 3;
    repeat (20) cycle(0, 0, 0);

    // Redirect with an outstanding request; stale word must be dropped
    mem_lat = 2;
    do_reset("rst1");
    cycle(0, 0, 0);
    force_data  = 32'hDEAD_BEEF;
    force_valid = 1;
    cycle(0, 1, 32'h0000_0102);
    chk("rd_pc_out", pc_out_o, 32'h100);
    chk("rd_bubble", 32'(bubble_out_o), 32'd1);
    chk("rd_req_held", 32'(imem_req_o), 32'd1);
    chk("rd_addr_old", imem_addr_o, 32'h0);
    repeat (2) cycle(0, 0, 0);
    chk("rd_after_discard_req", 32'(imem_req_o), 32'd0);
    cycle(0, 0, 0);
    chk("rd_new_addr", imem_addr_o, 32'h100);
    chk("rd_new_req", 32'(imem_req_o), 32'd1);
    repeat (4) cycle(0, 0, 0);
    chk("rd_new_instr", instr_out_o, 32'h100);
    chk("rd_new_pc", pc_out_o, 32'h100);
    chk("rd_new_bubble", 32'(bubble_out_o), 32'd0);

    // Redirect together with stall and ack
    mem_lat = 0;
    repeat (5) cycle(0, 0, 0);
    cycle(1, 1, 32'h0000_0200);
    chk("rsa_req", 32'(imem_req_o), 32'd0);
    chk("rsa_bubble", 32'(bubble_out_o), 32'd1);
    chk("rsa_pc", pc_out_o, 32'h200);
    chk("rsa_instr", instr_out_o, 32'h0);
    repeat (3) cycle(0, 0, 0);
    chk("rsa_first_new", instr_out_o, 32'h200);

    // PC wrap at the top of the address space
    cycle(0, 1, 32'hFFFF_FFFE);
    repeat (2) cycle(0, 0, 0);
    chk("wrap_addr", imem_addr_o, 32'h0);
    cycle(0, 0, 0);
    chk("wrap_instr_top", instr_out_o, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    chk("wrap_instr_zero", instr_out_o, 32'h0);
    chk("wrap_pc_zero", pc_out_o, 32'h0);
    chk("wrap_bubble", 32'(bubble_out_o), 32'd0);
    repeat (3) cycle(0, 0, 0);

    // Asynchronous reset mid-WAIT
    mem_lat = 3;
    repeat (2) cycle(0, 0, 0);
    chk("mid_wait_req", 32'(imem_req_o), 32'd1);
    do_reset("rst_mid");
    repeat (12) cycle(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
